// File: rtl/pio_mem_rd_arb.sv
// Round-robin read arbiter in front of a single PIO memory read port.
// Outstanding requester tags are queued so responses return in issue order.
module pio_mem_rd_arb #(
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 1,
  parameter int NREQ        = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*DEPTH_NBITS-1:0] req_addr,
  output logic [NREQ-1:0]             gnt,
  output logic                        app_mem_rd,
  output logic [DEPTH_NBITS-1:0]      app_mem_raddr,
  input  logic                        app_mem_ack,
  input  logic [WIDTH-1:0]            app_mem_rdata,
  output logic [NREQ-1:0]             rsp_ack,
  output logic [WIDTH-1:0]            rsp_rdata,
  output logic                        idle,
  output logic                        err_unexp_ack
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             found;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             can_grant;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(TAG_DEPTH));
  assign pop   = app_mem_ack && !empty;

  // A pop in the same cycle frees a slot, so a full queue may still grant.
  assign can_grant = !rst && arb_en && (!full || pop);

  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  assign push = found && can_grant;
  assign gnt  = push ? (ONE << gnt_idx) : '0;
  assign idle = empty && !app_mem_rd;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      app_mem_rd    <= 1'b0;
      app_mem_raddr <= '0;
      rsp_ack       <= '0;
      rsp_rdata     <= '0;
      err_unexp_ack <= 1'b0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      app_mem_rd <= push;
      if (push) begin
        app_mem_raddr <=
          req_addr[int'(gnt_idx)*DEPTH_NBITS +: DEPTH_NBITS];
        rr_ptr <= (gnt_idx == IDX_W'(NREQ-1)) ?
                  '0 : gnt_idx + IDX_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        rsp_ack   <= ONE << tag_mem[rd_ptr];
        rsp_rdata <= app_mem_rdata;
      end else begin
        rsp_ack <= '0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (app_mem_ack && empty) err_unexp_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Directed bench for pio_mem_rd_arb with hand-computed expectations.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_pio_mem_rd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req;
  logic [3:0]  req_addr;
  logic [3:0]  gnt;
  logic        app_mem_rd;
  logic [0:0]  app_mem_raddr;
  logic        app_mem_ack;
  logic [19:0] app_mem_rdata;
  logic [3:0]  rsp_ack;
  logic [19:0] rsp_rdata;
  logic        idle;
  logic        err_unexp_ack;

  int n_chk  = 0;
  int n_fail = 0;

  pio_mem_rd_arb #(
    .WIDTH(20), .DEPTH_NBITS(1), .NREQ(4), .TAG_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .req(req), .req_addr(req_addr), .gnt(gnt),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
    .idle(idle), .err_unexp_ack(err_unexp_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arb_en = 1'b1; req = 4'hF; req_addr = 4'h0;
    app_mem_ack = 1'b0; app_mem_rdata = '0;

    // Reset state, grants forced off while in reset
    tick(); tick(); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rd", 32'(app_mem_rd), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_err", 32'(err_unexp_ack), 32'h0);
    chk("rst_ack", 32'(rsp_ack), 32'h0);

    // Single read from requester 2 at address 1
    rst = 1'b0; req = 4'b0100; req_addr = 4'b0100; #1;
    chk("s_gnt", 32'(gnt), 32'h4);
    tick(); req = 4'h0; #1;
    chk("s_rd", 32'(app_mem_rd), 32'h1);
    chk("s_raddr", 32'(app_mem_raddr), 32'h1);
    chk("s_busy", 32'(idle), 32'h0);
    tick(); #1;
    chk("s_rd0", 32'(app_mem_rd), 32'h0);
    chk("s_raddr_hold", 32'(app_mem_raddr), 32'h1);
    tick();
    tick(); app_mem_ack = 1'b1; app_mem_rdata = 20'hABCDE;
    tick(); app_mem_ack = 1'b0; #1;
    chk("s_rsp", 32'(rsp_ack), 32'h4);
    chk("s_data", 32'(rsp_rdata), 32'hABCDE);
    tick(); #1;
    chk("s_rsp0", 32'(rsp_ack), 32'h0);
    chk("s_data_hold", 32'(rsp_rdata), 32'hABCDE);
    chk("s_idle", 32'(idle), 32'h1);

    // All four held high from reset
    do_reset();
    req = 4'hF; #1;
    chk("rr_g0", 32'(gnt), 32'h1);
    tick(); #1; chk("rr_g1", 32'(gnt), 32'h2);
    tick(); #1; chk("rr_g2", 32'(gnt), 32'h4);
    tick(); #1; chk("rr_g3", 32'(gnt), 32'h8);
    tick(); app_mem_ack = 1'b1; app_mem_rdata = 20'h00010; #1;
    chk("rr_g4_full_pop", 32'(gnt), 32'h1);
    tick(); req = 4'h0; app_mem_rdata = 20'h00011; #1;
    chk("rr_r0", 32'(rsp_ack), 32'h1);
    chk("rr_d0", 32'(rsp_rdata), 32'h00010);
    tick(); app_mem_rdata = 20'h00012; #1;
    chk("rr_r1", 32'(rsp_ack), 32'h2);
    chk("rr_d1", 32'(rsp_rdata), 32'h00011);
    tick(); app_mem_rdata = 20'h00013; #1;
    chk("rr_r2", 32'(rsp_ack), 32'h4);
    tick(); app_mem_rdata = 20'h00014; #1;
    chk("rr_r3", 32'(rsp_ack), 32'h8);
    chk("rr_d3", 32'(rsp_rdata), 32'h00013);
    tick(); app_mem_ack = 1'b0; #1;
    chk("rr_r4", 32'(rsp_ack), 32'h1);
    chk("rr_d4", 32'(rsp_rdata), 32'h00014);
    tick(); #1;
    chk("rr_done", 32'(rsp_ack), 32'h0);
    chk("rr_idle", 32'(idle), 32'h1);
    chk("rr_noerr", 32'(err_unexp_ack), 32'h0);

    // Stalled memory: four grants fill the tag queue
    do_reset();
    req = 4'hF; #1;
    chk("st_g0", 32'(gnt), 32'h1);
    tick(); #1; chk("st_g1", 32'(gnt), 32'h2);
    tick(); #1; chk("st_g2", 32'(gnt), 32'h4);
    tick(); #1; chk("st_g3", 32'(gnt), 32'h8);
    tick(); #1; chk("st_full", 32'(gnt), 32'h0);
    tick(); #1; chk("st_full2", 32'(gnt), 32'h0);
    app_mem_ack = 1'b1; app_mem_rdata = 20'h77777; #1;
    chk("st_pop_gnt", 32'(gnt), 32'h1);
    tick(); app_mem_ack = 1'b0; req = 4'h0; #1;
    chk("st_rsp", 32'(rsp_ack), 32'h1);
    chk("st_nogrant", 32'(gnt), 32'h0);

    // Unexpected ack while idle
    do_reset();
    app_mem_ack = 1'b1;
    tick(); app_mem_ack = 1'b0; #1;
    chk("ua_err", 32'(err_unexp_ack), 32'h1);
    chk("ua_rsp", 32'(rsp_ack), 32'h0);
    chk("ua_idle", 32'(idle), 32'h1);
    tick(); tick(); #1;
    chk("ua_sticky", 32'(err_unexp_ack), 32'h1);
    do_reset(); #1;
    chk("ua_clr", 32'(err_unexp_ack), 32'h0);

    // arb_en dropped after two grants
    req = 4'hF; #1;
    chk("en_g0", 32'(gnt), 32'h1);
    tick(); #1; chk("en_g1", 32'(gnt), 32'h2);
    tick(); arb_en = 1'b0; #1;
    chk("en_off", 32'(gnt), 32'h0);
    tick(); app_mem_ack = 1'b1; app_mem_rdata = 20'h0000A; #1;
    chk("en_off2", 32'(gnt), 32'h0);
    tick(); app_mem_rdata = 20'h0000B; #1;
    chk("en_r0", 32'(rsp_ack), 32'h1);
    tick(); app_mem_ack = 1'b0; #1;
    chk("en_r1", 32'(rsp_ack), 32'h2);
    chk("en_d1", 32'(rsp_rdata), 32'h0000B);
    tick(); #1;
    chk("en_r_none", 32'(rsp_ack), 32'h0);
    chk("en_idle", 32'(idle), 32'h1);
    chk("en_noerr", 32'(err_unexp_ack), 32'h0);

    // Reset with three reads outstanding
    req = 4'h0; arb_en = 1'b1;
    do_reset();
    req = 4'hF; req_addr = 4'b0010; #1;
    chk("mr_g0", 32'(gnt), 32'h1);
    tick(); #1; chk("mr_g1", 32'(gnt), 32'h2);
    tick(); #1;
    chk("mr_raddr", 32'(app_mem_raddr), 32'h1);
    tick(); app_mem_ack = 1'b1; app_mem_rdata = 20'h5A5A5; #1;
    chk("mr_g3", 32'(gnt), 32'h8);
    tick(); app_mem_ack = 1'b0; req = 4'h0; rst = 1'b1; #1;
    chk("mr_pre_rsp", 32'(rsp_ack), 32'h1);
    chk("mr_pre_data", 32'(rsp_rdata), 32'h5A5A5);
    req = 4'hF; #1;
    chk("mr_gnt_rst", 32'(gnt), 32'h0);
    tick(); rst = 1'b0; req = 4'h0; #1;
    chk("mr_rd", 32'(app_mem_rd), 32'h0);
    chk("mr_raddr0", 32'(app_mem_raddr), 32'h0);
    chk("mr_rsp", 32'(rsp_ack), 32'h0);
    chk("mr_data0", 32'(rsp_rdata), 32'h0);
    chk("mr_idle", 32'(idle), 32'h1);
    app_mem_ack = 1'b1;
    tick(); app_mem_ack = 1'b0; #1;
    chk("mr_late_err", 32'(err_unexp_ack), 32'h1);
    chk("mr_late_rsp", 32'(rsp_ack), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
